// File: rtl/ifm_rd_sched_if.sv
// ---------------------------------------------------------------------------
// ifm_rd_sched_if
//   Bundles the job-control, configuration, back-pressure and BRAM read-side
//   signals of the IFM read scheduler.
//
//   master : the job controller / testbench side (drives start, cfg_*, stall;
//            observes the read strobe, output tags and status).
//   slave  : the scheduler itself.
//
//   Signals
//     start            single-cycle job request
//     cfg_w/cfg_h      IFM width / height in pixels
//     cfg_cg           channel groups (4x8-bit channels per 32-bit word)
//     cfg_k            kernel size K
//     cfg_stride       stride S
//     cfg_pad          same-padding enable
//     stall            downstream back-pressure, one cycle ahead of need
//     rd_en, rd_addr   BRAM read strobe and byte address
//     out_valid/out_pad/out_last  beat tags aligned with BRAM data_out
//     busy/done/cfg_err           job status
// ---------------------------------------------------------------------------
interface ifm_rd_sched_if #(
    parameter int ADDR_W = 20
);
    logic              start;
    logic [7:0]        cfg_w;
    logic [7:0]        cfg_h;
    logic [5:0]        cfg_cg;
    logic [1:0]        cfg_k;
    logic [1:0]        cfg_stride;
    logic              cfg_pad;
    logic              stall;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic              out_valid;
    logic              out_pad;
    logic              out_last;
    logic              busy;
    logic              done;
    logic              cfg_err;

    modport master (
        output start, cfg_w, cfg_h, cfg_cg, cfg_k, cfg_stride, cfg_pad, stall,
        input  rd_en, rd_addr, out_valid, out_pad, out_last, busy, done, cfg_err
    );

    modport slave (
        input  start, cfg_w, cfg_h, cfg_cg, cfg_k, cfg_stride, cfg_pad, stall,
        output rd_en, rd_addr, out_valid, out_pad, out_last, busy, done, cfg_err
    );
endinterface

// File: rtl/ifm_rd_sched.sv
// ---------------------------------------------------------------------------
// ifm_rd_sched
//   Window-scan read scheduler for an input feature map held in a 32-bit
//   BRAM (one word = 4 channels of one pixel). For each output pixel
//   (oy, ox) it walks the K x K window and all channel groups, issuing one
//   read beat per cycle, innermost-to-outermost: cg, kx, ky, ox, oy.
//
//   Ports
//     clk   : single clock, rising edge
//     rst   : synchronous active-high reset
//     bus   : ifm_rd_sched_if.slave (start, cfg_*, stall in;
//             rd_en, rd_addr, out_valid, out_pad, out_last, busy, done,
//             cfg_err out)
//
//   Optional feature
//     IFM_RD_SCHED_PAD_EN : when defined, cfg_pad enables same-padding
//     (P=(K-1)/2) and out-of-image window taps are emitted as padded beats.
//     When undefined, P is always 0 and out_pad is constant 0.
//
//   Timing: all beat outputs are registered. A stall sampled at an edge
//   suppresses the beat that edge would have issued, so the downstream
//   raises stall one cycle ahead. out_valid follows the issued beat by one
//   cycle (BRAM read latency), done follows the out_valid carrying out_last.
// ---------------------------------------------------------------------------
module ifm_rd_sched #(
    parameter int ADDR_W = 20,
    parameter int DEPTH  = 26912
) (
    input  logic          clk,
    input  logic          rst,
    ifm_rd_sched_if.slave bus
);

`ifdef IFM_RD_SCHED_PAD_EN
    localparam logic PAD_EN = 1'b1;
`else
    localparam logic PAD_EN = 1'b0;
`endif

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    // Control / output registers
    state_t            state_q, state_d;
    logic              all_q, all_d;          // final beat already issued
    logic              rd_en_q, rd_en_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic              iss_q, iss_d;          // a beat was issued this cycle
    logic              iss_pad_q, iss_pad_d;
    logic              iss_last_q, iss_last_d;
    logic              ov_q, ov_d;
    logic              opad_q, opad_d;
    logic              olast_q, olast_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    // Latched job configuration
    logic [7:0]        w_q, w_d;
    logic [7:0]        h_q, h_d;
    logic [5:0]        cg_q, cg_d;
    logic [1:0]        k_q, k_d;
    logic              s2_q, s2_d;            // stride is 2
    logic              p_q, p_d;              // padding P (0 or 1)
    logic [9:0]        oh_q, oh_d;
    logic [9:0]        ow_q, ow_d;

    // Window-scan counters (point at the next beat to issue)
    logic [5:0]        cgc_q, cgc_d;
    logic [1:0]        kx_q, kx_d;
    logic [1:0]        ky_q, ky_d;
    logic [9:0]        ox_q, ox_d;
    logic [9:0]        oy_q, oy_d;

    // Start-time configuration evaluation (straight from the inputs)
    logic              p_new;
    logic [9:0]        wp_new, hp_new;
    logic [31:0]       words_new;
    logic              err_new;
    logic [9:0]        oh_span, ow_span;
    logic [9:0]        oh_new, ow_new;

    always_comb begin
        // P=(K-1)/2 is non-zero only for K=3
        p_new     = PAD_EN && bus.cfg_pad && (bus.cfg_k == 2'd3);
        wp_new    = {2'b00, bus.cfg_w} + {8'b0, p_new, 1'b0};
        hp_new    = {2'b00, bus.cfg_h} + {8'b0, p_new, 1'b0};
        words_new = 32'(bus.cfg_w) * 32'(bus.cfg_h) * 32'(bus.cfg_cg);
        // A stride of 3 fits the field but has no defined meaning; reject it.
        err_new   = (bus.cfg_w == 8'd0) || (bus.cfg_h == 8'd0) ||
                    (bus.cfg_cg == 6'd0) || (bus.cfg_k == 2'd0) ||
                    (bus.cfg_stride == 2'd0) || (bus.cfg_stride == 2'd3) ||
                    (words_new > 32'(DEPTH)) ||
                    ({8'b0, bus.cfg_k} > wp_new) ||
                    ({8'b0, bus.cfg_k} > hp_new);
        oh_span   = hp_new - {8'b0, bus.cfg_k};
        ow_span   = wp_new - {8'b0, bus.cfg_k};
        oh_new    = ((bus.cfg_stride == 2'd2) ? (oh_span >> 1) : oh_span) + 10'd1;
        ow_new    = ((bus.cfg_stride == 2'd2) ? (ow_span >> 1) : ow_span) + 10'd1;
    end

    // Current beat: input coordinates, padding and byte address
    logic [10:0]       oy_sc, ox_sc;
    logic signed [11:0] iy_s, ix_s;
    logic              oob;
    logic [31:0]       pix, addr_full;
    logic              cg_wrap, kx_wrap, ky_wrap, ox_wrap, oy_wrap, last_beat;

    always_comb begin
        oy_sc     = s2_q ? {oy_q, 1'b0} : {1'b0, oy_q};
        ox_sc     = s2_q ? {ox_q, 1'b0} : {1'b0, ox_q};
        iy_s      = $signed({1'b0, oy_sc}) + $signed({10'b0, ky_q}) - $signed({11'b0, p_q});
        ix_s      = $signed({1'b0, ox_sc}) + $signed({10'b0, kx_q}) - $signed({11'b0, p_q});
        oob       = (iy_s < 12'sd0) || (iy_s >= $signed({4'b0, h_q})) ||
                    (ix_s < 12'sd0) || (ix_s >= $signed({4'b0, w_q}));
        // Only meaningful when !oob, then both coordinates are non-negative.
        pix       = 32'(iy_s[10:0]) * 32'(w_q) + 32'(ix_s[10:0]);
        addr_full = (pix * 32'(cg_q) + 32'(cgc_q)) << 2;

        cg_wrap   = (cgc_q == cg_q - 6'd1);
        kx_wrap   = (kx_q == k_q - 2'd1);
        ky_wrap   = (ky_q == k_q - 2'd1);
        ox_wrap   = (ox_q == ow_q - 10'd1);
        oy_wrap   = (oy_q == oh_q - 10'd1);
        last_beat = cg_wrap && kx_wrap && ky_wrap && ox_wrap && oy_wrap;
    end

    // Next-state logic
    always_comb begin
        state_d    = state_q;
        all_d      = all_q;
        rd_en_d    = 1'b0;
        rd_addr_d  = rd_addr_q;
        iss_d      = 1'b0;
        iss_pad_d  = 1'b0;
        iss_last_d = 1'b0;
        ov_d       = iss_q;
        opad_d     = iss_pad_q;
        olast_d    = iss_last_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        w_d        = w_q;
        h_d        = h_q;
        cg_d       = cg_q;
        k_d        = k_q;
        s2_d       = s2_q;
        p_d        = p_q;
        oh_d       = oh_q;
        ow_d       = ow_q;
        cgc_d      = cgc_q;
        kx_d       = kx_q;
        ky_d       = ky_q;
        ox_d       = ox_q;
        oy_d       = oy_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    if (err_new) begin
                        err_d  = 1'b1;
                        done_d = 1'b1;
                    end else begin
                        w_d     = bus.cfg_w;
                        h_d     = bus.cfg_h;
                        cg_d    = bus.cfg_cg;
                        k_d     = bus.cfg_k;
                        s2_d    = (bus.cfg_stride == 2'd2);
                        p_d     = p_new;
                        oh_d    = oh_new;
                        ow_d    = ow_new;
                        cgc_d   = '0;
                        kx_d    = '0;
                        ky_d    = '0;
                        ox_d    = '0;
                        oy_d    = '0;
                        all_d   = 1'b0;
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (!all_q && !bus.stall) begin
                    iss_d      = 1'b1;
                    iss_pad_d  = oob;
                    iss_last_d = last_beat;
                    rd_en_d    = !oob;
                    // Padded beats leave the address where it was.
                    if (!oob) begin
                        rd_addr_d = ADDR_W'(addr_full);
                    end
                    all_d = last_beat;
                    // Ripple-carry advance of the nested loop counters
                    if (!cg_wrap) begin
                        cgc_d = cgc_q + 6'd1;
                    end else begin
                        cgc_d = '0;
                        if (!kx_wrap) begin
                            kx_d = kx_q + 2'd1;
                        end else begin
                            kx_d = '0;
                            if (!ky_wrap) begin
                                ky_d = ky_q + 2'd1;
                            end else begin
                                ky_d = '0;
                                if (!ox_wrap) begin
                                    ox_d = ox_q + 10'd1;
                                end else begin
                                    ox_d = '0;
                                    oy_d = oy_q + 10'd1;
                                end
                            end
                        end
                    end
                end
                if (ov_q && olast_q) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            all_q      <= 1'b0;
            rd_en_q    <= 1'b0;
            rd_addr_q  <= '0;
            iss_q      <= 1'b0;
            iss_pad_q  <= 1'b0;
            iss_last_q <= 1'b0;
            ov_q       <= 1'b0;
            opad_q     <= 1'b0;
            olast_q    <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            all_q      <= all_d;
            rd_en_q    <= rd_en_d;
            rd_addr_q  <= rd_addr_d;
            iss_q      <= iss_d;
            iss_pad_q  <= iss_pad_d;
            iss_last_q <= iss_last_d;
            ov_q       <= ov_d;
            opad_q     <= opad_d;
            olast_q    <= olast_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
        // Configuration and scan counters are only read while RUN,
        // which is always entered through a fresh load.
        w_q   <= w_d;
        h_q   <= h_d;
        cg_q  <= cg_d;
        k_q   <= k_d;
        s2_q  <= s2_d;
        p_q   <= p_d;
        oh_q  <= oh_d;
        ow_q  <= ow_d;
        cgc_q <= cgc_d;
        kx_q  <= kx_d;
        ky_q  <= ky_d;
        ox_q  <= ox_d;
        oy_q  <= oy_d;
    end

    assign bus.rd_en     = rd_en_q;
    assign bus.rd_addr   = rd_addr_q;
    assign bus.out_valid = ov_q;
    assign bus.out_pad   = PAD_EN & opad_q;
    assign bus.out_last  = olast_q;
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.done      = done_q;
    assign bus.cfg_err   = err_q;

endmodule

// File: tb/tb_ifm_rd_sched.sv
// ---------------------------------------------------------------------------
// tb_ifm_rd_sched
//   Randomized self-checking bench for ifm_rd_sched. A reference model
//   expands each job configuration into the ordered list of expected beats
//   (padding flag and byte address) directly from the window-scan rules.
//   Each out_valid is matched against the next expected beat using the
//   rd_en/rd_addr seen on the previous cycle.
// ---------------------------------------------------------------------------
module tb_ifm_rd_sched;
    localparam int ADDR_W = 20;
    localparam int DEPTH  = 26912;
`ifdef IFM_RD_SCHED_PAD_EN
    localparam bit PAD_MODEL = 1'b1;
`else
    localparam bit PAD_MODEL = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ifm_rd_sched_if #(.ADDR_W(ADDR_W)) bus ();

    ifm_rd_sched #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    int exp_addr[$];
    bit exp_pad[$];

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Expected beat list for one job, built from the scan rules.
    task automatic build_model(input int w, input int h, input int cg, input int k,
                               input int s, input bit pad, output bit err);
        int p, oh, ow, iy, ix;
        p = (PAD_MODEL && pad) ? (k - 1) / 2 : 0;
        exp_addr.delete();
        exp_pad.delete();
        err = (w == 0) || (h == 0) || (cg == 0) || (k == 0) || (s == 0) || (s == 3) ||
              (w * h * cg > DEPTH) || (k > w + 2 * p) || (k > h + 2 * p);
        if (!err) begin
            oh = (h + 2 * p - k) / s + 1;
            ow = (w + 2 * p - k) / s + 1;
            for (int oy = 0; oy < oh; oy++)
                for (int ox = 0; ox < ow; ox++)
                    for (int ky = 0; ky < k; ky++)
                        for (int kx = 0; kx < k; kx++)
                            for (int c = 0; c < cg; c++) begin
                                iy = oy * s + ky - p;
                                ix = ox * s + kx - p;
                                if (iy < 0 || iy >= h || ix < 0 || ix >= w) begin
                                    exp_pad.push_back(1'b1);
                                    exp_addr.push_back(0);
                                end else begin
                                    exp_pad.push_back(1'b0);
                                    exp_addr.push_back(((iy * w + ix) * cg + c) * 4);
                                end
                            end
        end
    endtask

    task automatic rand_cfg();
        bus.cfg_w      = 8'($urandom);
        bus.cfg_h      = 8'($urandom);
        bus.cfg_cg     = 6'($urandom);
        bus.cfg_k      = 2'($urandom);
        bus.cfg_stride = 2'($urandom);
        bus.cfg_pad    = 1'($urandom);
    endtask

    task automatic check_reset_outputs(input string name);
        check_val({name, ":rst_rd_en"},   32'(bus.rd_en), 0);
        check_val({name, ":rst_rd_addr"}, 32'(bus.rd_addr), 0);
        check_val({name, ":rst_valid"},   32'(bus.out_valid), 0);
        check_val({name, ":rst_pad"},     32'(bus.out_pad), 0);
        check_val({name, ":rst_last"},    32'(bus.out_last), 0);
        check_val({name, ":rst_busy"},    32'(bus.busy), 0);
        check_val({name, ":rst_done"},    32'(bus.done), 0);
        check_val({name, ":rst_cfg_err"}, 32'(bus.cfg_err), 0);
    endtask

    // stall_pct : random stall probability in percent
    // burst_at  : if >0, stall exactly 3 edges starting at that loop cycle
    // abort_at  : if >0, assert rst when the abort_at-th read strobe is seen
    // exp_beats : required beat count, or -1 to take it from the model
    task automatic run_job(input string name, input int w, input int h, input int cg,
                           input int k, input int s, input bit pad, input int stall_pct,
                           input int burst_at, input int abort_at, input int exp_beats);
        bit                err;
        int                total, n, cyc, iss, budget, first_ov, last_ov;
        bit                prev_en, en, last_prev, stall_edge;
        logic [ADDR_W-1:0] prev_addr, addr;

        build_model(w, h, cg, k, s, pad, err);
        total = exp_addr.size();

        @(posedge clk);
        #1;
        bus.cfg_w      = 8'(w);
        bus.cfg_h      = 8'(h);
        bus.cfg_cg     = 6'(cg);
        bus.cfg_k      = 2'(k);
        bus.cfg_stride = 2'(s);
        bus.cfg_pad    = pad;
        bus.stall      = 1'b0;
        bus.start      = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        rand_cfg();

        if (err) begin
            @(negedge clk);
            check_val({name, ":cfg_err"}, 32'(bus.cfg_err), 1);
            check_val({name, ":err_done"}, 32'(bus.done), 1);
            check_val({name, ":err_busy"}, 32'(bus.busy), 0);
            check_val({name, ":err_rd_en"}, 32'(bus.rd_en), 0);
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                check_val({name, ":err_quiet"},
                          32'({bus.out_valid, bus.rd_en, bus.busy, bus.done, bus.cfg_err}), 0);
            end
            if (exp_beats >= 0) check_val({name, ":beats"}, 0, 32'(exp_beats));
            return;
        end

        prev_en    = 1'b0;
        prev_addr  = bus.rd_addr;
        stall_edge = 1'b0;
        last_prev  = 1'b0;
        n          = 0;
        cyc        = 0;
        iss        = 0;
        first_ov   = -1;
        last_ov    = -1;
        budget     = total * 4 + 50;

        forever begin
            @(negedge clk);
            cyc++;
            en   = bus.rd_en;
            addr = bus.rd_addr;
            check_val({name, ":busy"}, 32'(bus.busy), 1);
            if (stall_edge) begin
                check_val({name, ":stall_rd_en"}, 32'(en), 0);
                check_val({name, ":stall_addr"}, 32'(addr), 32'(prev_addr));
            end
            if (bus.out_valid) begin
                if (n < total) begin
                    check_val({name, ":pad"}, 32'(bus.out_pad), 32'(exp_pad[n]));
                    check_val({name, ":rd_en"}, 32'(prev_en), 32'(!exp_pad[n]));
                    if (!exp_pad[n])
                        check_val({name, ":addr"}, 32'(prev_addr), 32'(exp_addr[n]));
                    check_val({name, ":last"}, 32'(bus.out_last), 32'(n == total - 1));
                    if (first_ov < 0) first_ov = cyc;
                    last_ov = cyc;
                end else begin
                    check_val({name, ":extra_beat"}, 1, 0);
                end
                n++;
            end
            check_val({name, ":done"}, 32'(bus.done), 32'(last_prev));
            last_prev = bus.out_valid && bus.out_last;
            if (en) iss++;

            if (abort_at > 0 && iss == abort_at) begin
                rst = 1'b1;
                @(posedge clk);
                #1;
                rst       = 1'b0;
                bus.stall = 1'b0;
                bus.start = 1'b0;
                @(negedge clk);
                check_reset_outputs(name);
                for (int i = 0; i < 4; i++) begin
                    @(negedge clk);
                    check_val({name, ":abort_quiet"},
                              32'({bus.out_valid, bus.done, bus.busy}), 0);
                end
                return;
            end

            if (bus.done) break;

            if (cyc > budget) begin
                check_val({name, ":timeout"}, 0, 1);
                rst = 1'b1;
                @(posedge clk);
                #1;
                rst       = 1'b0;
                bus.stall = 1'b0;
                bus.start = 1'b0;
                return;
            end

            prev_en   = en;
            prev_addr = addr;
            @(posedge clk);
            stall_edge = bus.stall;
            #1;
            if (burst_at > 0)
                bus.stall = (cyc >= burst_at) && (cyc < burst_at + 3);
            else
                bus.stall = ($urandom_range(0, 99) < stall_pct);
            // Starts while busy must be ignored; cfg changes must not leak in.
            bus.start = ($urandom_range(0, 9) == 0);
            rand_cfg();
        end

        bus.start = 1'b0;
        bus.stall = 1'b0;
        check_val({name, ":beats"}, 32'(n), (exp_beats >= 0) ? 32'(exp_beats) : 32'(total));
        if (stall_pct == 0 && burst_at == 0)
            check_val({name, ":contiguous"}, 32'(last_ov - first_ov), 32'(total - 1));
        @(negedge clk);
        check_val({name, ":idle_busy"}, 32'(bus.busy), 0);
        check_val({name, ":idle_done"}, 32'(bus.done), 0);
    endtask

    initial begin
        int rw, rh, rcg, rk, rs, rstall;
        bit rpad;

        rst = 1'b1;
        bus.stall      = 1'b0;
        bus.cfg_w      = 8'd4;
        bus.cfg_h      = 8'd4;
        bus.cfg_cg     = 6'd1;
        bus.cfg_k      = 2'd1;
        bus.cfg_stride = 2'd1;
        bus.cfg_pad    = 1'b0;
        bus.start      = 1'b1;      // reset must win over start
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        bus.start = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_val("reset:still_idle", 32'(bus.busy), 0);

        run_job("basic",   4, 4, 1, 1, 1, 1'b0, 0, 0, 0, 16);
        run_job("k3cg2",   4, 4, 2, 3, 1, 1'b0, 0, 0, 0, 72);
        run_job("pad",     4, 4, 1, 3, 1, 1'b1, 0, 0, 0, PAD_MODEL ? 144 : 36);
        run_job("burst",   4, 4, 2, 3, 1, 1'b0, 0, 20, 0, 72);
        run_job("toobig",  255, 255, 63, 3, 1, 1'b0, 0, 0, 0, 0);
        run_job("kwide",   2, 4, 1, 3, 1, 1'b0, 0, 0, 0, 0);
        run_job("abort",   4, 4, 1, 1, 1, 1'b0, 0, 0, 10, -1);
        run_job("rerun",   4, 4, 1, 1, 1, 1'b0, 0, 0, 0, 16);
        run_job("stride2", 7, 5, 2, 3, 2, 1'b1, 25, 0, 0, -1);

        for (int j = 0; j < 14; j++) begin
            rw     = $urandom_range(1, 8);
            rh     = $urandom_range(1, 8);
            rcg    = $urandom_range(1, 3);
            rk     = $urandom_range(1, 3);
            rs     = $urandom_range(1, 2);
            rpad   = 1'($urandom);
            rstall = $urandom_range(0, 40);
            run_job($sformatf("rand%0d", j), rw, rh, rcg, rk, rs, rpad, rstall, 0, 0, -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
